// File: rtl/pto_axis_sequencer.sv
// Three-axis step/direction pulse-train sequencer: latches one coordinated move,
// applies direction, waits a setup delay, then runs all axes from a common start cycle.
module pto_axis_sequencer #(
    parameter int CNT_W     = 32,
    parameter int PER_W     = 16,
    parameter int DIR_SETUP = 50
) (
    input  logic                 clk_clk,
    input  logic                 reset_reset_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [3*CNT_W-1:0]   cmd_steps,
    input  logic [3*PER_W-1:0]   cmd_half_period,
    input  logic [2:0]           cmd_dir,
    input  logic                 abort,
    output logic                 busy,
    output logic                 done,
    output logic                 aborted,
    output logic [2:0]           pto,
    output logic [2:0]           motor_dir
);

    // state | meaning
    // IDLE  | waiting for a command, cmd_ready high
    // SETUP | direction applied, counting the setup delay
    // RUN   | pulse trains active until every axis has finished
    // DONE  | one-cycle completion pulse
    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_RUN, S_DONE} state_t;

    localparam int            SW         = $clog2(DIR_SETUP + 1);
    localparam logic [SW-1:0] SETUP_LOAD = SW'(DIR_SETUP - 1);

    state_t           state_q, state_d;
    logic [SW-1:0]    setup_cnt_q, setup_cnt_d;
    logic [CNT_W-1:0] steps_q [3];
    logic [CNT_W-1:0] steps_d [3];
    logic [PER_W-1:0] half_q  [3];
    logic [PER_W-1:0] half_d  [3];
    logic [PER_W-1:0] phase_q [3];
    logic [PER_W-1:0] phase_d [3];
    logic [2:0]       pto_q, pto_d;
    logic [2:0]       dir_q, dir_d;
    logic             done_q, done_d;
    logic             aborted_q, aborted_d;
    logic             busy_q, busy_d;
    logic             ready_q, ready_d;
    logic [2:0]       fin_next;

    always_comb begin
        state_d     = state_q;
        setup_cnt_d = setup_cnt_q;
        steps_d     = steps_q;
        half_d      = half_q;
        phase_d     = phase_q;
        pto_d       = pto_q;
        dir_d       = dir_q;
        busy_d      = busy_q;
        ready_d     = ready_q;
        done_d      = 1'b0;
        aborted_d   = 1'b0;
        fin_next    = '0;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    for (int i = 0; i < 3; i++) begin
                        steps_d[i] = cmd_steps[i*CNT_W +: CNT_W];
                        // a zero half-period would never toggle; run it as one cycle
                        half_d[i]  = (cmd_half_period[i*PER_W +: PER_W] == '0) ?
                                     PER_W'(1) : cmd_half_period[i*PER_W +: PER_W];
                        phase_d[i] = '0;
                    end
                    dir_d       = cmd_dir;
                    setup_cnt_d = SETUP_LOAD;
                    busy_d      = 1'b1;
                    ready_d     = 1'b0;
                    state_d     = S_SETUP;
                end
            end
            S_SETUP: begin
                if (abort) begin
                    pto_d     = '0;
                    done_d    = 1'b1;
                    aborted_d = 1'b1;
                    state_d   = S_DONE;
                end else if (setup_cnt_q == '0) begin
                    for (int i = 0; i < 3; i++) begin
                        if (steps_q[i] != '0) begin
                            pto_d[i]   = 1'b1;
                            phase_d[i] = half_q[i] - PER_W'(1);
                        end
                    end
                    state_d = S_RUN;
                end else begin
                    setup_cnt_d = setup_cnt_q - SW'(1);
                end
            end
            S_RUN: begin
                if (abort) begin
                    pto_d     = '0;
                    done_d    = 1'b1;
                    aborted_d = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    for (int i = 0; i < 3; i++) begin
                        fin_next[i] = 1'b1;
                        if (steps_q[i] != '0) begin
                            fin_next[i] = 1'b0;
                            if (phase_q[i] != '0) begin
                                phase_d[i] = phase_q[i] - PER_W'(1);
                            end else if (pto_q[i]) begin
                                pto_d[i]   = 1'b0;
                                phase_d[i] = half_q[i] - PER_W'(1);
                            end else begin
                                // end of low phase: the step is complete
                                steps_d[i] = steps_q[i] - CNT_W'(1);
                                if (steps_q[i] == CNT_W'(1)) begin
                                    fin_next[i] = 1'b1;
                                end else begin
                                    pto_d[i]   = 1'b1;
                                    phase_d[i] = half_q[i] - PER_W'(1);
                                end
                            end
                        end
                    end
                    if (&fin_next) begin
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                ready_d = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q     <= S_IDLE;
            setup_cnt_q <= '0;
            for (int i = 0; i < 3; i++) begin
                steps_q[i] <= '0;
                half_q[i]  <= '0;
                phase_q[i] <= '0;
            end
            pto_q     <= '0;
            dir_q     <= '0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            busy_q    <= 1'b0;
            ready_q   <= 1'b1;
        end else begin
            state_q     <= state_d;
            setup_cnt_q <= setup_cnt_d;
            steps_q     <= steps_d;
            half_q      <= half_d;
            phase_q     <= phase_d;
            pto_q       <= pto_d;
            dir_q       <= dir_d;
            done_q      <= done_d;
            aborted_q   <= aborted_d;
            busy_q      <= busy_d;
            ready_q     <= ready_d;
        end
    end

    assign cmd_ready = ready_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign aborted   = aborted_q;
    assign pto       = pto_q;
    assign motor_dir = dir_q;

endmodule

// File: tb/tb_pto_axis_sequencer.sv
// Bench for pto_axis_sequencer: directed and random moves compared cycle by cycle
// against a waveform model derived from step count, half-period and start cycle.
module tb_pto_axis_sequencer;

    localparam int CNT_W = 32;
    localparam int PER_W = 16;
    localparam int D     = 4;

    logic               clk_clk = 1'b0;
    logic               reset_reset_n = 1'b0;
    logic               cmd_valid = 1'b0;
    logic               cmd_ready;
    logic [3*CNT_W-1:0] cmd_steps = '0;
    logic [3*PER_W-1:0] cmd_half_period = '0;
    logic [2:0]         cmd_dir = '0;
    logic               abort = 1'b0;
    logic               busy;
    logic               done;
    logic               aborted;
    logic [2:0]         pto;
    logic [2:0]         motor_dir;

    int n_tests = 0;
    int n_fail  = 0;

    pto_axis_sequencer #(.CNT_W(CNT_W), .PER_W(PER_W), .DIR_SETUP(D)) dut (
        .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_steps(cmd_steps), .cmd_half_period(cmd_half_period), .cmd_dir(cmd_dir),
        .abort(abort), .busy(busy), .done(done), .aborted(aborted),
        .pto(pto), .motor_dir(motor_dir)
    );

    always #5 clk_clk = ~clk_clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // cycle (relative to acceptance) at which done is seen for an un-aborted move
    function automatic int calc_tend(input int s0, s1, s2, h0, h1, h2);
        int s[3];
        int h[3];
        int mx;
        s[0] = s0; s[1] = s1; s[2] = s2;
        h[0] = (h0 == 0) ? 1 : h0;
        h[1] = (h1 == 0) ? 1 : h1;
        h[2] = (h2 == 0) ? 1 : h2;
        mx = 0;
        for (int i = 0; i < 3; i++)
            if (h[i] * s[i] > mx) mx = h[i] * s[i];
        return (mx == 0) ? 2 + D : 1 + D + 2 * mx;
    endfunction

    task automatic run_move(input int s0, s1, s2, h0, h1, h2, input logic [2:0] d,
                            input int abort_at, input bit chained_in, input bit chain_out);
        int s[3];
        int h[3];
        int tend, last, t;
        logic [2:0] p;
        s[0] = s0; s[1] = s1; s[2] = s2;
        h[0] = (h0 == 0) ? 1 : h0;
        h[1] = (h1 == 0) ? 1 : h1;
        h[2] = (h2 == 0) ? 1 : h2;
        tend = (abort_at > 0) ? abort_at + 1 : calc_tend(s0, s1, s2, h0, h1, h2);
        if (!chained_in) @(negedge clk_clk);
        cmd_steps       = {CNT_W'(s2), CNT_W'(s1), CNT_W'(s0)};
        cmd_half_period = {PER_W'(h2), PER_W'(h1), PER_W'(h0)};
        cmd_dir         = d;
        cmd_valid       = 1'b1;
        if (chained_in) begin
            @(posedge clk_clk);
            @(negedge clk_clk);
        end
        check_val("idle_ready", {busy, cmd_ready, done, aborted}, 4'b0100);
        @(posedge clk_clk);
        last = chain_out ? tend : tend + 1;
        for (int j = 1; j <= last; j++) begin
            @(negedge clk_clk);
            t = j - (1 + D);
            for (int i = 0; i < 3; i++)
                p[i] = (t >= 0) && (t < 2 * h[i] * s[i]) && (((t / h[i]) % 2) == 0);
            if (abort_at > 0 && j > abort_at) p = '0;
            check_val($sformatf("cyc%0d", j),
                      {busy, cmd_ready, done, aborted, motor_dir, pto},
                      {j <= tend, j > tend, j == tend, (abort_at > 0) && (j == tend), d, p});
            cmd_valid = 1'b0;
            abort     = (abort_at > 0) && (j == abort_at);
        end
        abort = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int rs[3];
        int rh[3];
        int tn, ab;
        bit ch_in, ch_out;

        #12;
        check_val("reset_state", {busy, cmd_ready, done, aborted, motor_dir, pto}, 10'b0100_000_000);
        @(negedge clk_clk);
        reset_reset_n = 1'b1;

        run_move(3, 0, 0, 2, 2, 2, 3'b001, 0, 0, 0);
        run_move(2, 4, 1, 5, 1, 3, 3'b110, 0, 0, 0);
        run_move(10, 0, 0, 4, 1, 1, 3'b010, 1 + D + 2, 0, 0);
        run_move(2, 0, 0, 0, 0, 0, 3'b011, 0, 0, 0);
        run_move(0, 0, 0, 3, 3, 3, 3'b111, 0, 0, 0);
        run_move(3, 3, 3, 1, 1, 1, 3'b100, 2, 0, 0);

        // abort while idle must not start or end anything
        @(negedge clk_clk);
        abort = 1'b1;
        @(negedge clk_clk);
        check_val("abort_idle", {busy, cmd_ready, done, aborted}, 4'b0100);
        abort = 1'b0;

        run_move(1, 2, 0, 1, 2, 1, 3'b101, 0, 0, 1);
        run_move(2, 1, 1, 2, 3, 1, 3'b010, 0, 1, 0);

        ch_in = 1'b0;
        for (int k = 0; k < 30; k++) begin
            for (int i = 0; i < 3; i++) begin
                rs[i] = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 5);
                rh[i] = $urandom_range(0, 4);
            end
            tn = calc_tend(rs[0], rs[1], rs[2], rh[0], rh[1], rh[2]);
            ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, tn - 1) : 0;
            ch_out = (k != 29) && ($urandom_range(0, 1) == 1);
            run_move(rs[0], rs[1], rs[2], rh[0], rh[1], rh[2], 3'($urandom_range(0, 7)),
                     ab, ch_in, ch_out);
            ch_in = ch_out;
        end

        // asynchronous reset in the middle of a run
        @(negedge clk_clk);
        cmd_steps       = {CNT_W'(0), CNT_W'(0), CNT_W'(10)};
        cmd_half_period = {PER_W'(1), PER_W'(1), PER_W'(4)};
        cmd_dir         = 3'b101;
        cmd_valid       = 1'b1;
        @(posedge clk_clk);
        @(negedge clk_clk);
        cmd_valid = 1'b0;
        repeat (D + 1) @(negedge clk_clk);
        check_val("pre_reset_run", {busy, motor_dir, pto}, 7'b1_101_001);
        #2;
        reset_reset_n = 1'b0;
        #1;
        check_val("async_reset", {busy, cmd_ready, done, aborted, motor_dir, pto}, 10'b0100_000_000);
        @(negedge clk_clk);
        reset_reset_n = 1'b1;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk_clk);
            check_val("post_reset_idle", {busy, cmd_ready, done, aborted, pto}, 7'b0100_000);
        end
        run_move(2, 1, 3, 1, 2, 1, 3'b011, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
